// File: rtl/audio_mix_sched.sv
// Time-multiplexed stereo mixer: one shared adder, one channel per cycle, clamped/wrapped output.
// Build option: define MIX_SAT_EN to saturate the final sums; otherwise they wrap to 16 bits.
module audio_mix_sched #(
    parameter int NUM_SRC = 4,
    parameter int ACC_W   = 16 + $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_stb,
    input  logic [16*NUM_SRC-1:0]     src_l,
    input  logic [16*NUM_SRC-1:0]     src_r,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [2*NUM_SRC-1:0]      src_att,
    output logic signed [15:0]        out_l,
    output logic signed [15:0]        out_r,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
);

    // state | meaning
    // IDLE  | waiting for sample_stb
    // ACC   | one shared-adder step per cycle, even idx -> left, odd idx -> right
    // DONE  | convert sums to outputs; a strobe here restarts without a gap
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    localparam int IDX_W = $clog2(2*NUM_SRC);
    localparam int SEL_W = IDX_W - 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2*NUM_SRC-1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    state_t state, state_nx;

    logic signed [15:0]    lat_l   [NUM_SRC];
    logic signed [15:0]    lat_r   [NUM_SRC];
    logic [1:0]            lat_att [NUM_SRC];
    logic [NUM_SRC-1:0]    lat_en;
    logic signed [ACC_W-1:0] acc_l, acc_r;
    logic [IDX_W-1:0]      idx;

    logic                  start, stb_ignored;
    logic [SEL_W-1:0]      sel;
    logic signed [15:0]    x, shifted;
    logic signed [ACC_W-1:0] term, acc_a, sum;
    logic signed [15:0]    mix_l, mix_r;

    function automatic logic signed [15:0] conv(input logic signed [ACC_W-1:0] a);
`ifdef MIX_SAT_EN
        if (a > SAT_HI)      return 16'sh7fff;
        else if (a < SAT_LO) return 16'sh8000;
        else                 return a[15:0];
`else
        return a[15:0];
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (sample_stb) state_nx = S_ACC;
            S_ACC:  if (idx == IDX_LAST) state_nx = S_DONE;
            S_DONE: state_nx = sample_stb ? S_ACC : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        start       = sample_stb && (state == S_IDLE || state == S_DONE);
        stb_ignored = sample_stb && (state == S_ACC);
    end

    // Single shared adder: operand and destination chosen by idx parity
    always_comb begin
        sel     = idx[IDX_W-1:1];
        x       = idx[0] ? lat_r[sel] : lat_l[sel];
        shifted = x >>> lat_att[sel];
        term    = lat_en[sel] ? {{(ACC_W-16){shifted[15]}}, shifted} : '0;
        acc_a   = idx[0] ? acc_r : acc_l;
        sum     = acc_a + term;
        mix_l   = conv(acc_l);
        mix_r   = conv(acc_r);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                lat_l[i]   <= '0;
                lat_r[i]   <= '0;
                lat_att[i] <= '0;
            end
            lat_en    <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            idx       <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                out_l <= mix_l;
                out_r <= mix_r;
            end
            if (stb_ignored) overrun <= 1'b1;
            if (start) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    lat_l[i]   <= src_l[16*i +: 16];
                    lat_r[i]   <= src_r[16*i +: 16];
                    lat_att[i] <= src_att[2*i +: 2];
                end
                lat_en <= src_en;
                acc_l  <= '0;
                acc_r  <= '0;
                idx    <= '0;
            end else if (state == S_ACC) begin
                if (idx[0]) acc_r <= sum;
                else        acc_l <= sum;
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_mix_sched.sv
// Self-checking bench for audio_mix_sched (NUM_SRC=4): directed table plus randomized streams vs. a sum model.
module tb_audio_mix_sched;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_stb;
    logic [63:0]        src_l, src_r;
    logic [3:0]         src_en;
    logic [7:0]         src_att;
    logic signed [15:0] out_l, out_r;
    logic               out_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    audio_mix_sched #(.NUM_SRC(4)) dut (
        .clk(clk), .reset(reset), .sample_stb(sample_stb),
        .src_l(src_l), .src_r(src_r), .src_en(src_en), .src_att(src_att),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] l, r;
        logic [3:0]  en;
        logic [7:0]  att;
        logic [15:0] exp_l, exp_r;
    } vec_t;

    typedef struct {
        int          c;
        logic [15:0] l, r;
    } exp_t;

    vec_t vecs[5];
    exp_t q[$];
    int   plan[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer sum of enabled, shifted sources, then clamp or wrap
    function automatic logic [15:0] model(input logic [63:0] v, input logic [3:0] en,
                                          input logic [7:0] att);
        int sum = 0;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            logic signed [15:0] s;
            int xi;
            s  = v[16*i +: 16];
            xi = int'(s);
            if (en[i]) sum += xi >>> att[2*i +: 2];
        end
`ifdef MIX_SAT_EN
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
`endif
        t = sum;
        return t[15:0];
    endfunction

    function automatic vec_t mk(input logic [63:0] l, input logic [63:0] r, input logic [3:0] en,
                                input logic [7:0] att, input logic [15:0] el, input logic [15:0] er);
        vec_t v;
        v.l = l; v.r = r; v.en = en; v.att = att; v.exp_l = el; v.exp_r = er;
        return v;
    endfunction

    task automatic rand_inputs();
        src_l   = {$urandom, $urandom};
        src_r   = {$urandom, $urandom};
        src_en  = 4'($urandom);
        src_att = 8'($urandom);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input int n);
        int lat = 0;
        logic [15:0] held;
        @(negedge clk);
        src_l = vecs[n].l; src_r = vecs[n].r; src_en = vecs[n].en; src_att = vecs[n].att;
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        rand_inputs();
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) check($sformatf("vec%0d_busy", n), 16'(busy), 16'd1);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check($sformatf("vec%0d_latency", n), 16'(lat), 16'd9);
        check($sformatf("vec%0d_out_l", n), out_l, vecs[n].exp_l);
        check($sformatf("vec%0d_out_r", n), out_r, vecs[n].exp_r);
        held = out_l;
        @(posedge clk); #1;
        check($sformatf("vec%0d_valid_one_cycle", n), 16'(out_valid), 16'd0);
        check($sformatf("vec%0d_hold", n), out_l, held);
    endtask

    // Drives strobes at the cycles in plan; acceptance follows the 9-cycle minimum spacing rule
    task automatic run_stream(input string name, input int ncyc, output int pulses,
                              output logic exp_ovr);
        int last_acc = -100;
        pulses  = 0;
        exp_ovr = 1'b0;
        q.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            rand_inputs();
            if (plan.size() > 0 && plan[0] == c) begin
                exp_t e;
                void'(plan.pop_front());
                sample_stb = 1'b1;
                if (c - last_acc >= 9) begin
                    e.c = c;
                    e.l = model(src_l, src_en, src_att);
                    e.r = model(src_r, src_en, src_att);
                    q.push_back(e);
                    last_acc = c;
                end else begin
                    exp_ovr = 1'b1;
                end
            end else begin
                sample_stb = 1'b0;
            end
            @(posedge clk); #1;
            if (q.size() > 0 && q[0].c + 9 == c) begin
                check({name, "_valid"}, 16'(out_valid), 16'd1);
                check({name, "_out_l"}, out_l, q[0].l);
                check({name, "_out_r"}, out_r, q[0].r);
                if (out_valid) pulses++;
                void'(q.pop_front());
            end else if (out_valid) begin
                check({name, "_spurious_valid"}, 16'(out_valid), 16'd0);
                pulses++;
            end
        end
        sample_stb = 1'b0;
        check({name, "_pending_left"}, 16'(q.size()), 16'd0);
    endtask

    initial begin
        int   pulses;
        logic exp_ovr;
        int   cnt;

        reset = 1'b1; sample_stb = 1'b0;
        src_l = '0; src_r = '0; src_en = '0; src_att = '0;

        vecs[0] = mk(64'h0000_0000_07D0_03E8, 64'h0000_0000_01F4_FC18, 4'hF, 8'h00, 16'h0BB8, 16'hFE0C);
`ifdef MIX_SAT_EN
        vecs[1] = mk(64'h7000_7000_7000_7000, 64'h9000_9000_9000_9000, 4'hF, 8'h00, 16'h7FFF, 16'h8000);
`else
        vecs[1] = mk(64'h7000_7000_7000_7000, 64'h9000_9000_9000_9000, 4'hF, 8'h00, 16'hC000, 16'h4000);
`endif
        vecs[2] = mk(64'h0000_C000_4000_4000, 64'h0, 4'b1101, 8'h12, 16'hF000, 16'h0000);
        vecs[3] = mk(64'h0000_0000_FFF9_FFFF, 64'h0064_0000_0000_0000, 4'hF, 8'hC7, 16'hFFFB, 16'h000C);
        vecs[4] = mk(64'h7FFF_8000_1234_ABCD, 64'h7FFF_8000_1234_ABCD, 4'h0, 8'hFF, 16'h0000, 16'h0000);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_l", out_l, 16'd0);
        check("rst_out_r", out_r, 16'd0);
        check("rst_valid", 16'(out_valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_overrun", 16'(overrun), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 5; n++) run_vec(n);
        check("no_overrun_after_table", 16'(overrun), 16'd0);

        pulse_reset();
        plan = '{0, 4, 9};
        run_stream("ovr", 30, pulses, exp_ovr);
        check("ovr_pulses", 16'(pulses), 16'd2);
        check("ovr_sticky", 16'(overrun), 16'(exp_ovr));

        pulse_reset();
        plan.delete();
        for (int i = 0; i < 10; i++) plan.push_back(9 * i);
        run_stream("b2b", 100, pulses, exp_ovr);
        check("b2b_pulses", 16'(pulses), 16'd10);
        check("b2b_overrun", 16'(overrun), 16'(exp_ovr));

        pulse_reset();
        plan.delete();
        begin
            int c = 0;
            while (c < 250) begin
                plan.push_back(c);
                c += $urandom_range(1, 14);
            end
        end
        run_stream("rnd", 270, pulses, exp_ovr);
        check("rnd_overrun", 16'(overrun), 16'(exp_ovr));

        // Reset sampled at the 5th edge after the strobe edge
        @(negedge clk);
        src_l = vecs[0].l; src_r = vecs[0].r; src_en = vecs[0].en; src_att = vecs[0].att;
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_l", out_l, 16'd0);
        check("midrst_out_r", out_r, 16'd0);
        check("midrst_valid", 16'(out_valid), 16'd0);
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_overrun", 16'(overrun), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        check("midrst_no_valid", 16'(cnt), 16'd0);
        run_vec(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
